// File: rtl/cpu_ctl_pkg.sv
// Shared control-word layout and sequencer state encoding for the CPU control path.
// Bit positions are the contract between the microcode image, the sequencer and the splitter.
package cpu_ctl_pkg;

    localparam int CW_BITS = 32;

    // Field positions inside the 32-bit control word
    localparam int OUTCTL_LSB  = 0;
    localparam int OUTCTL_MSB  = 3;
    localparam int LOADCTL_LSB = 4;
    localparam int LOADCTL_MSB = 7;
    localparam int ALU_LSB     = 8;
    localparam int ALU_MSB     = 15;
    localparam int ADDR_LSB    = 16;
    localparam int ADDR_MSB    = 23;
    localparam int STEP_RESETN = 24;
    localparam int STEP_EXTN   = 25;
    localparam int CLK_HALT    = 26;
    localparam int CLK_BRK     = 27;

    // No bus drive, no loads, step bits inactive (high), no halt/break request
    localparam logic [CW_BITS-1:0] CW_IDLE = 32'h0300_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        BREAK = 2'd2
    } seq_state_t;

endpackage

// File: rtl/microcode_rom.sv
// Microcode ROM with asynchronous read; contents are written into the array by the
// surrounding environment (a testbench fills it directly).
module microcode_rom #(
  parameter int    ADDR_BITS = 16,
  parameter int    DATA_BITS = 32,
  parameter string ROM_FILE  = "microcode.hex"
) (
  input  logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] data
);

  logic [DATA_BITS-1:0] mem [0:(2**ADDR_BITS)-1];

  assign data = mem[addr];

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-step sequencer: step counter, extended-page bit and RUN/HALT/BREAK FSM,
// producing the control word for the current step from the microcode ROM.
module microcode_sequencer
    import cpu_ctl_pkg::*;
#(
    parameter int    STEP_BITS   = 3,
    parameter int    OPCODE_BITS = 8,
    parameter int    FLAG_BITS   = 4,
    parameter int    CW_WIDTH    = 32,
    parameter string ROM_FILE    = "microcode.hex"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic [FLAG_BITS-1:0]   flags,
    input  logic                   cont,
    output logic [CW_WIDTH-1:0]    control_word,
    output logic [STEP_BITS-1:0]   step,
    output logic                   halted,
    output logic                   in_break,
    output logic                   step_ovf
);

    localparam int ADDR_BITS = 1 + FLAG_BITS + OPCODE_BITS + STEP_BITS;

    seq_state_t           state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic                 ext_q, ext_d;
    logic                 ovf_q, ovf_d;

    logic [ADDR_BITS-1:0] rom_addr;
    logic [CW_WIDTH-1:0]  rom_data;

    assign rom_addr = {ext_q, flags, opcode, step_q};

    microcode_rom #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (CW_WIDTH),
        .ROM_FILE  (ROM_FILE)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    // Outside RUN the splitter sees an idle word, so sequencing bits are inactive too
    assign control_word = (state_q == RUN) ? rom_data : CW_WIDTH'(CW_IDLE);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ext_d   = ext_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                if (!control_word[STEP_RESETN]) begin
                    step_d = '0;
                    ext_d  = 1'b0;
                end else if (!control_word[STEP_EXTN]) begin
                    step_d = '0;
                    ext_d  = 1'b1;
                end else begin
                    step_d = step_q + STEP_BITS'(1);
                    if (&step_q) begin
                        ovf_d = 1'b1;
                    end
                end
                // Halt outranks break when microcode requests both
                if (control_word[CLK_HALT]) begin
                    state_d = HALT;
                end else if (control_word[CLK_BRK]) begin
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (cont) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            step_q  <= '0;
            ext_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ext_q   <= ext_d;
            ovf_q   <= ovf_d;
        end
    end

    assign step     = step_q;
    assign halted   = (state_q == HALT);
    assign in_break = (state_q == BREAK);
    assign step_ovf = ovf_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: loads a small microcode image into the ROM
// array and walks through step reset, page jump, flag select, break, halt and wrap.
module tb_microcode_sequencer;

    logic        clk;
    logic        reset;
    logic [7:0]  opcode;
    logic [3:0]  flags;
    logic        cont;
    logic [31:0] control_word;
    logic [2:0]  step;
    logic        halted;
    logic        in_break;
    logic        step_ovf;

    int total;
    int bad;

    microcode_sequencer #(
        .STEP_BITS   (3),
        .OPCODE_BITS (8),
        .FLAG_BITS   (4),
        .CW_WIDTH    (32),
        .ROM_FILE    ("")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .flags        (flags),
        .cont         (cont),
        .control_word (control_word),
        .step         (step),
        .halted       (halted),
        .in_break     (in_break),
        .step_ovf     (step_ovf)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_a(input logic e, input logic [3:0] f,
                                          input logic [7:0] o, input logic [2:0] s);
        return {e, f, o, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        opcode = 8'h00;
        flags  = 4'h0;
        cont   = 1'b0;

        // Default every word to "end of instruction" so stray addresses stay benign
        for (int i = 0; i < 65536; i++) dut.u_rom.mem[i] = 32'h0200_0000;
        // opcode 00: three steps, ends at step 2
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h00, 0)] = 32'h0300_0001;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h00, 1)] = 32'h0300_0002;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h00, 2)] = 32'h0200_0003;
        // opcode 10: jump to extended page at step 1
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h10, 0)] = 32'h0300_0010;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h10, 1)] = 32'h0100_0011;
        dut.u_rom.mem[rom_a(1, 4'h0, 8'h10, 0)] = 32'h0300_0012;
        dut.u_rom.mem[rom_a(1, 4'h0, 8'h10, 1)] = 32'h0200_0013;
        // opcode 20: flag-dependent words
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h20, 0)] = 32'h0300_00A0;
        dut.u_rom.mem[rom_a(0, 4'h2, 8'h20, 0)] = 32'h0300_00A2;
        dut.u_rom.mem[rom_a(0, 4'h2, 8'h20, 1)] = 32'h0200_00A3;
        // opcode 30: break at step 3, ends at step 4
        for (int s = 0; s < 3; s++) dut.u_rom.mem[rom_a(0, 4'h0, 8'h30, 3'(s))] = 32'h0300_0030 + s;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h30, 3)] = 32'h0B00_0033;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h30, 4)] = 32'h0200_0034;
        // opcode 40: halt and break together at step 1
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h40, 0)] = 32'h0300_0040;
        dut.u_rom.mem[rom_a(0, 4'h0, 8'h40, 1)] = 32'h0F00_0041;
        // opcode 50: eight steps, never resets
        for (int s = 0; s < 8; s++) dut.u_rom.mem[rom_a(0, 4'h0, 8'h50, 3'(s))] = 32'h0300_0050 + s;

        tick();
        tick();
        reset = 1'b0;

        // 1. reset state and a three-step instruction
        check("rst_cw", control_word, 32'h0300_0001);
        check("rst_step", {29'd0, step}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_break", {31'd0, in_break}, 32'd0);
        check("rst_ovf", {31'd0, step_ovf}, 32'd0);
        tick();
        check("op00_s1_cw", control_word, 32'h0300_0002);
        check("op00_s1_step", {29'd0, step}, 32'd1);
        tick();
        check("op00_s2_cw", control_word, 32'h0200_0003);
        tick();
        check("op00_wrap_step", {29'd0, step}, 32'd0);
        check("op00_wrap_cw", control_word, 32'h0300_0001);

        // 2. extended page jump and return
        opcode = 8'h10;
        #1;
        check("op10_s0_cw", control_word, 32'h0300_0010);
        tick();
        check("op10_s1_cw", control_word, 32'h0100_0011);
        tick();
        check("op10_ext_step", {29'd0, step}, 32'd0);
        check("op10_ext_s0_cw", control_word, 32'h0300_0012);
        tick();
        check("op10_ext_s1_cw", control_word, 32'h0200_0013);
        tick();
        check("op10_back_cw", control_word, 32'h0300_0010);

        // 3. flags select distinct words combinationally
        opcode = 8'h20;
        #1;
        check("op20_f0_cw", control_word, 32'h0300_00A0);
        flags = 4'b0010;
        #1;
        check("op20_f2_cw", control_word, 32'h0300_00A2);
        tick();
        check("op20_f2_s1_cw", control_word, 32'h0200_00A3);
        tick();
        check("op20_end_step", {29'd0, step}, 32'd0);
        flags = 4'b0000;

        // 4. break at step 3, hold with cont low, resume
        opcode = 8'h30;
        tick();
        tick();
        tick();
        check("op30_s3_cw", control_word, 32'h0B00_0033);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("brk_cw", control_word, 32'h0300_0000);
            check("brk_step", {29'd0, step}, 32'd4);
            check("brk_flag", {31'd0, in_break}, 32'd1);
            tick();
        end
        check("brk_hold_halted", {31'd0, halted}, 32'd0);
        cont = 1'b1;
        tick();
        cont = 1'b0;
        check("resume_break", {31'd0, in_break}, 32'd0);
        check("resume_step", {29'd0, step}, 32'd4);
        check("resume_cw", control_word, 32'h0200_0034);
        tick();
        check("op30_end_step", {29'd0, step}, 32'd0);

        // 5. halt wins over break; cont ignored; only reset leaves
        opcode = 8'h40;
        tick();
        check("op40_s1_cw", control_word, 32'h0F00_0041);
        tick();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_nobrk", {31'd0, in_break}, 32'd0);
        check("halt_cw", control_word, 32'h0300_0000);
        check("halt_step", {29'd0, step}, 32'd2);
        cont = 1'b1;
        tick();
        tick();
        cont = 1'b0;
        check("halt_cont_ign", {31'd0, halted}, 32'd1);
        check("halt_step_frz", {29'd0, step}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_step", {29'd0, step}, 32'd0);
        check("halt_rst_cw", control_word, 32'h0300_0040);

        // 6. step wrap sets sticky overflow; reset mid-instruction clears everything
        opcode = 8'h50;
        for (int c = 0; c < 7; c++) tick();
        check("op50_s7_step", {29'd0, step}, 32'd7);
        check("op50_s7_ovf", {31'd0, step_ovf}, 32'd0);
        tick();
        check("wrap_step", {29'd0, step}, 32'd0);
        check("wrap_ovf", {31'd0, step_ovf}, 32'd1);
        check("wrap_cw", control_word, 32'h0300_0050);
        for (int c = 0; c < 5; c++) tick();
        check("ovf_sticky", {31'd0, step_ovf}, 32'd1);
        check("mid_step5", {29'd0, step}, 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_step", {29'd0, step}, 32'd0);
        check("mid_rst_ovf", {31'd0, step_ovf}, 32'd0);
        check("mid_rst_cw", control_word, 32'h0300_0050);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
